// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment display scan path.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SCAN_W     = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle of the enable/digit inputs and the scan/anode outputs of the display controller.
interface display_scan_ctrl_if;

    logic                                                    enable;
    logic [display_pkg::NUM_DIGITS*display_pkg::DIGIT_W-1:0] digits_in;
    logic [display_pkg::NUM_DIGITS*display_pkg::DIGIT_W-1:0] digits_out;
    logic [display_pkg::SCAN_W-1:0]                          scan;
    logic [display_pkg::NUM_DIGITS-1:0]                      an_n;
    logic                                                    digit_tick;
    logic                                                    frame_done;

    modport master (
        output enable, digits_in,
        input  digits_out, scan, an_n, digit_tick, frame_done
    );

    modport slave (
        input  enable, digits_in,
        output digits_out, scan, an_n, digit_tick, frame_done
    );

endinterface

// File: rtl/display_scan_ctrl_lz_blank_mask.sv
// Leading-zero mask: digit k (k >= 1) is masked when it and every digit above it are zero.
module lz_blank_mask
    import display_pkg::*;
#(
    parameter bit LZ_BLANK = 1'b1
) (
    // Digit 0 is never masked, so only nibbles 1..3 are needed.
    input  logic [(NUM_DIGITS-1)*DIGIT_W-1:0] digits_hi,
    output logic [NUM_DIGITS-1:0]             mask
);

    // zero_from[k] is set when nibbles k..3 are all zero.
    logic [NUM_DIGITS:1] zero_from;

    assign zero_from[NUM_DIGITS] = 1'b1;
    assign mask[0]               = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
            assign zero_from[gi] = (digits_hi[(gi-1)*DIGIT_W +: DIGIT_W] == '0) && zero_from[gi+1];
            assign mask[gi]      = LZ_BLANK && zero_from[gi];
        end
    endgenerate

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment refresh controller: slot timing, anode drive with dead time,
// and a frame-coherent snapshot of the digit values.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW    = NUM_DIGITS * DIGIT_W;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SCAN_W-1:0]       scan_q, scan_d;
    logic [DW-1:0]           digits_out_q, digits_out_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    digit_tick_q, digit_tick_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   mask;

    // Mask is taken from the next snapshot so it lines up with the registered an_n.
    lz_blank_mask #(
        .LZ_BLANK (LZ_BLANK)
    ) u_lz_blank_mask (
        .digits_hi (digits_out_d[DW-1:DIGIT_W]),
        .mask      (mask)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scan_d       = scan_q;
        digits_out_d = digits_out_q;
        digit_tick_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d      = RUN;
                    digits_out_d = bus.digits_in;
                    cnt_d        = '0;
                    scan_d       = '0;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    scan_d  = '0;
                end else if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d        = '0;
                    scan_d       = scan_q + SCAN_W'(1);
                    digit_tick_d = 1'b1;
                    if (scan_q == SCAN_W'(NUM_DIGITS - 1)) begin
                        digits_out_d = bus.digits_in;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Anodes are decoded from next-state values so the flop tracks cnt/scan exactly.
        an_n_d = AN_OFF;
        if ((state_d == RUN) && (cnt_d >= CNT_W'(BLANK_CYCLES)) && !mask[scan_d]) begin
            an_n_d = ~(NUM_DIGITS'(1) << scan_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            scan_q       <= '0;
            digits_out_q <= '0;
            an_n_q       <= AN_OFF;
            digit_tick_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scan_q       <= scan_d;
            digits_out_q <= digits_out_d;
            an_n_q       <= an_n_d;
            digit_tick_q <= digit_tick_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digits_out = digits_out_q;
    assign bus.scan       = scan_q;
    assign bus.an_n       = an_n_q;
    assign bus.digit_tick = digit_tick_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (DIV=8, BLANK_CYCLES=2) with leading-zero blanking on and off.
module tb_display_scan_ctrl;

    import display_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    display_scan_ctrl_if bus_lz ();
    display_scan_ctrl_if bus_all ();

    display_scan_ctrl #(.DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut_lz (
        .clock (clock),
        .reset (reset),
        .bus   (bus_lz)
    );

    display_scan_ctrl #(.DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut_all (
        .clock (clock),
        .reset (reset),
        .bus   (bus_all)
    );

    typedef struct {
        logic [1:0]  scan;
        logic [3:0]  an_lz;
        logic [3:0]  an_all;
        logic [15:0] dout;
        logic        tick;
        logic        fd;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;

    // Reference: t counts cycles since the run started; slot = t/8 mod 4, position = t mod 8.
    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_snap = 16'h0000;

    function automatic logic [3:0] exp_an(bit run, int t, logic [15:0] snap, bit lz);
        int          slot;
        int          pos;
        logic [15:0] upper;
        slot = (t / 8) % 4;
        pos  = t % 8;
        if (!run || pos < 2) return 4'b1111;
        if (lz && slot != 0) begin
            upper = snap >> (4 * slot);
            if (upper == 16'h0000) return 4'b1111;
        end
        return ~(4'b0001 << slot);
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, ncyc, obs, exp);
        end
    endtask

    task automatic cyc(bit rst, bit en, logic [15:0] din);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset             = rst;
        bus_lz.enable     = en;
        bus_lz.digits_in  = din;
        bus_all.enable    = en;
        bus_all.digits_in = din;

        e.tick = 1'b0;
        e.fd   = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_snap = 16'h0000;
        end else if (!m_run) begin
            if (en) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_snap = din;
            end
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            m_t++;
            if (m_t % 8 == 0) e.tick = 1'b1;
            if (m_t % 32 == 0) begin
                e.fd   = 1'b1;
                m_snap = din;
            end
        end
        e.scan   = m_run ? 2'((m_t / 8) % 4) : 2'd0;
        e.an_lz  = exp_an(m_run, m_t, m_snap, 1'b1);
        e.an_all = exp_an(m_run, m_t, m_snap, 1'b0);
        e.dout   = m_snap;
        sb.push_back(e);

        @(posedge clock);
        #1;
        ncyc++;
        got = sb.pop_front();
        $display("cyc %0d rst=%0b en=%0b din=%h | scan=%0d an_lz=%b an_all=%b dout=%h tick=%0b fd=%0b",
                 ncyc, rst, en, din, bus_lz.scan, bus_lz.an_n, bus_all.an_n,
                 bus_lz.digits_out, bus_lz.digit_tick, bus_lz.frame_done);
        check("scan",       {14'b0, bus_lz.scan},       {14'b0, got.scan});
        check("an_n_lz",    {12'b0, bus_lz.an_n},       {12'b0, got.an_lz});
        check("digits_out", bus_lz.digits_out,          got.dout);
        check("digit_tick", {15'b0, bus_lz.digit_tick}, {15'b0, got.tick});
        check("frame_done", {15'b0, bus_lz.frame_done}, {15'b0, got.fd});
        check("an_n_all",   {12'b0, bus_all.an_n},      {12'b0, got.an_all});
        check("scan_all",   {14'b0, bus_all.scan},      {14'b0, got.scan});
    endtask

    initial begin
        bus_lz.enable     = 1'b0;
        bus_lz.digits_in  = 16'h0000;
        bus_all.enable    = 1'b0;
        bus_all.digits_in = 16'h0000;

        // Reset, then idle with enable low: nothing latched, no pulses.
        cyc(1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 16'h1234);

        // Normal scan, then a mid-frame write that only lands at the 3->0 wrap.
        for (int i = 0; i < 41; i++) cyc(1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 16'hABCD);

        // Drop enable at scan=2, cnt=5, idle a little, then restart a fresh slot.
        for (int i = 0; i < 64 && !(m_run && m_t % 32 == 21); i++) cyc(1'b0, 1'b1, 16'hABCD);
        cyc(1'b0, 1'b0, 16'hABCD);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'hABCD);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'hABCD);

        // Leading zeros: 0050 lights digits 1 and 0 only; 0000 lights digit 0 only.
        cyc(1'b0, 1'b0, 16'h0050);
        for (int i = 0; i < 36; i++) cyc(1'b0, 1'b1, 16'h0050);
        cyc(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 36; i++) cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0300);
        for (int i = 0; i < 34; i++) cyc(1'b0, 1'b1, 16'h0300);

        // One-cycle reset mid-slot with enable high, then resume with a fresh snapshot.
        for (int i = 0; i < 16 && !(m_run && m_t % 8 == 4); i++) cyc(1'b0, 1'b1, 16'h0907);
        cyc(1'b1, 1'b1, 16'h0907);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 16'h0907);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplex controller for the 4-digit seven-segment display; sits directly upstream of the 4-to-1 nibble mux in the display path. It owns the refresh timing: it generates the 2-bit `scan` select that drives the mux, the matching active-low digit anodes, and an inter-digit dead time that suppresses ghosting. It also holds a frame-coherent snapshot of the four BCD/hex digits, so the value on the display never tears mid-frame.

## Interface
- `DIV`, 50000: clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: dead-time cycles at the start of each slot, anodes off; must be ≥ 1.
- `LZ_BLANK`, 1: 1 turns off leading-zero digits; 0 always lights all digits.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  display on; level-sensitive.
- `digits_in`  in  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `digits_out`  out  16  latched snapshot; nibble k feeds mux `input`k.
- `scan`  out  2  digit select to the mux `scan` port.
- `an_n`  out  4  active-low anode enables; bit k corresponds to digit k.
- `digit_tick`  out  1  one-cycle pulse on every slot change.
- `frame_done`  out  1  one-cycle pulse when `scan` wraps from 3 to 0.

## Operation
- The state machine has two states, IDLE and RUN. The slot counter `cnt` runs from 0 to `DIV`-1.
- Reset sets the state to IDLE and drives the outputs as follows:
  - `cnt`=0, `scan`=0, `an_n`=4'b1111, `digits_out`=0.
  - `digit_tick`=0, `frame_done`=0.
- IDLE → RUN on the edge where `enable`=1:
  - `digits_out` ← `digits_in`.
  - `cnt` ← 0, `scan` ← 0.
- In RUN, `cnt` increments every cycle. At `cnt`=`DIV`-1:
  - `cnt` ← 0 and `scan` ← `scan`+1 (wraps modulo 4).
  - `digit_tick` pulses.
  - On a wrap from 3 to 0, `digits_out` is also reloaded from `digits_in` and `frame_done` pulses.
- RUN → IDLE on any edge where `enable`=0:
  - `cnt` and `scan` return to 0 and `an_n`=1111.
  - `digits_out` holds its value.
  - No pulses are generated.
- Anode drive in RUN:
  - `cnt` < `BLANK_CYCLES`: `an_n`=1111.
  - Otherwise: `an_n` = ~(1 << `scan`), unless digit `scan` is masked, in which case 1111.
- Leading-zero mask, computed from `digits_out` and active only when `LZ_BLANK`=1:
  - Digit k (k = 1..3) is masked if nibbles k..3 are all zero.
  - Digit 0 is never masked.
- `digits_in` is sampled only at a frame boundary or at IDLE→RUN. Changes in between have no effect until the next wrap.
- `reset` overrides `enable` and is legal at any cycle.

## Timing
- All outputs come directly from registers; there is no combinational path from any input to any output.
- Each slot is exactly `DIV` cycles long. A frame is 4·`DIV` cycles.
- `scan`, `digit_tick`, `frame_done` and the `digits_out` reload all change on the same edge.
- That edge is the one where `cnt` goes from `DIV`-1 to 0.
- `an_n` reflects the registered `cnt` and `scan`, so a lit digit turns on the cycle `cnt` becomes `BLANK_CYCLES`.
- `an_n` is therefore 1111 for the first `BLANK_CYCLES` cycles of every slot. This guarantees `scan` and the downstream mux output settle before any anode turns on.
- After `enable` falls, `an_n`=1111 on the next cycle.
- After `enable` rises, the first digit lights `BLANK_CYCLES`+1 cycles later.

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS`=4, `DIGIT_W`=4, `SCAN_W`=2.
  - State enum with IDLE and RUN.
  - Active-low anode constant `AN_OFF`=4'b1111.
- One sub-module, `lz_blank_mask`: a combinational `digits_out` → 4-bit mask, instantiated once. The counter and FSM stay in the top level.

## Test plan
All scenarios use `DIV`=8 and `BLANK_CYCLES`=2.
- Reset, then hold `enable`=0 → `an_n`=1111, `scan`=0, `digits_out`=0, no pulses for 50 cycles.
- `digits_in`=16'h1234, raise `enable` → `scan` steps 0,1,2,3,0 every 8 cycles; `an_n`=1110 / 1101 / 1011 / 0111 on cycles 2–7 of the respective slots and 1111 on cycles 0–1; `frame_done` pulses every 32 cycles.
- Leading zeros with `LZ_BLANK`=1:
  - `digits_in`=16'h0050 → digits 3 and 2 never light; digits 1 and 0 light normally.
  - `digits_in`=16'h0000 → only `an_n`=1110 ever appears.
  - With `LZ_BLANK`=0 → all four digits light.
- Write `digits_in`=16'hABCD mid-frame (`scan`=1) → `digits_out` keeps 16'h1234 until the 3→0 wrap, then becomes 16'hABCD on the same edge as `frame_done`.
- Drop `enable` at `scan`=2, `cnt`=5 → next cycle `an_n`=1111 and `scan`=0; re-raise → a full fresh slot at `scan`=0 with no `digit_tick` on entry.
- Assert `reset` for 1 cycle mid-slot with `enable`=1 → all outputs at their reset values on the next cycle; RUN resumes afterwards with a fresh `digits_out` snapshot.
